// File: rtl/fpa_pkg.sv
// fpa_pkg: shared types and constants for the floating-point adder arbiter.
//   fp32_t          - raw IEEE-754 single-precision bit pattern
//   fpa_tag_t       - {valid, id} tag that travels alongside an adder operation
//   FPA_DEFAULT_LAT - default adder latency (launch edge to capture edge)
package fpa_pkg;

  typedef logic [31:0] fp32_t;

  // Tag id is sized for the largest supported requester count (16);
  // the arbiter uses only the low $clog2(NUM_REQ) bits.
  localparam int FPA_ID_MAX_W    = 4;
  localparam int FPA_DEFAULT_LAT = 2;

  typedef struct packed {
    logic                    valid;
    logic [FPA_ID_MAX_W-1:0] id;
  } fpa_tag_t;

endpackage

// File: rtl/fpa_rsp_fifo.sv
// fpa_rsp_fifo: first-word fall-through result FIFO holding {id, data}.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   push, push_id/data    write one entry (caller guarantees not full)
//   pop                   remove head entry; ignored while empty
//   empty, count          occupancy status
//   head_id, head_data    current head entry, forced to zero while empty
module fpa_rsp_fifo
  import fpa_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int ID_W  = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [ID_W-1:0]  push_id,
  input  logic [31:0]      push_data,
  input  logic             pop,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [ID_W-1:0]  head_id,
  output logic [31:0]      head_data
);

  logic [ID_W-1:0]  id_mem   [DEPTH];
  fp32_t            data_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop = pop && (count_reg != '0);

  // Storage needs no reset: entries are only visible through count_reg.
  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wr_ptr_reg]   <= push_id;
      data_mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)   wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  // Zero the head while empty so the response port reads 0 after reset.
  assign head_id   = empty ? '0 : id_mem[rd_ptr_reg];
  assign head_data = empty ? '0 : data_mem[rd_ptr_reg];

endmodule

// File: rtl/fpa_arbiter.sv
// fpa_arbiter: shares one fixed-latency floating-point adder among NUM_REQ
// requesters with round-robin arbitration, an id tag pipeline matching the
// adder latency, and a credit-protected result FIFO.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (req_ready one-hot or zero)
//   req_a, req_b          per-requester operands, packed NUM_REQ x 32
//   fpa_a, fpa_b          registered operands to the adder
//   fpa_out               adder result, valid ADDER_LAT edges after launch
//   rsp_valid/rsp_ready   shared response handshake
//   rsp_id, rsp_data      issuing requester and raw sum bits
module fpa_arbiter
  import fpa_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int ADDER_LAT  = FPA_DEFAULT_LAT,
  parameter  int FIFO_DEPTH = 4,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [31:0]          fpa_a,
  output logic [31:0]          fpa_b,
  input  logic [31:0]          fpa_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [31:0]          rsp_data
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W = $clog2(ADDER_LAT + 1);

  fp32_t            req_a_arr [NUM_REQ];
  fp32_t            req_b_arr [NUM_REQ];
  fpa_tag_t         tag_reg   [ADDER_LAT];
  logic [ID_W-1:0]  rr_ptr_reg;
  logic [INF_W-1:0] inflight_reg;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_empty;
  logic             has_credit;
  logic             found;
  logic [ID_W-1:0]  grant_id;
  logic [ID_W:0]    probe;
  logic             issue;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_a_arr[gi] = req_a[gi*32 +: 32];
    assign req_b_arr[gi] = req_b[gi*32 +: 32];
  end

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
    return (v == ID_W'(NUM_REQ - 1)) ? '0 : v + ID_W'(1);
  endfunction

  // Round-robin search: first valid request at or after rr_ptr.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    probe    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      probe = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
      if (probe >= (ID_W+1)'(NUM_REQ)) probe = probe - (ID_W+1)'(NUM_REQ);
      if (!found && req_valid[probe[ID_W-1:0]]) begin
        found    = 1'b1;
        grant_id = probe[ID_W-1:0];
      end
    end
  end

  // Every launched-but-uncaptured op and every queued result holds one
  // FIFO slot, so a push can never land on a full FIFO.
  assign has_credit = (32'(fifo_count) + 32'(inflight_reg)) < 32'(FIFO_DEPTH);
  // rst_n gates the grant so req_ready reads 0 throughout reset.
  assign issue      = rst_n && found && has_credit;

  always_comb begin
    req_ready = '0;
    if (issue) req_ready[grant_id] = 1'b1;
  end

  assign fifo_push = tag_reg[ADDER_LAT-1].valid;
  assign fifo_pop  = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpa_a        <= '0;
      fpa_b        <= '0;
      rr_ptr_reg   <= '0;
      inflight_reg <= '0;
    end else begin
      if (issue) begin
        fpa_a      <= req_a_arr[grant_id];
        fpa_b      <= req_b_arr[grant_id];
        rr_ptr_reg <= wrap_inc(grant_id);
      end
      case ({issue, fifo_push})
        2'b10:   inflight_reg <= inflight_reg + INF_W'(1);
        2'b01:   inflight_reg <= inflight_reg - INF_W'(1);
        default: ;
      endcase
    end
  end

  // Tag pipeline: stage 0 marks a launch, last stage lines up with fpa_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < ADDER_LAT; s++) tag_reg[s] <= '0;
    end else begin
      tag_reg[0].valid <= issue;
      tag_reg[0].id    <= FPA_ID_MAX_W'(grant_id);
      for (int s = 1; s < ADDER_LAT; s++) tag_reg[s] <= tag_reg[s-1];
    end
  end

  fpa_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .ID_W  (ID_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_id   (tag_reg[ADDER_LAT-1].id[ID_W-1:0]),
    .push_data (fpa_out),
    .pop       (fifo_pop),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head_id   (rsp_id),
    .head_data (rsp_data)
  );

  assign rsp_valid = !fifo_empty;

endmodule
